// File: rtl/pnr_sysbus_master.sv
// System-bus initiator: one command at a time over valid/ready, one strobe, one response.
// Optional readback verify of writes is enabled with `define PNR_SYSBUS_RDBACK_VERIFY_EN.
module pnr_sysbus_master #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] VERIFY_MASK = 32'h0000_3FFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        rsp_mismatch_o,
  output logic        busy_o,
  output logic [31:0] sys_addr_o,
  output logic [31:0] sys_wdata_o,
  output logic        sys_wen_o,
  output logic        sys_ren_o,
  input  logic [31:0] sys_rdata_i,
  input  logic        sys_err_i,
  input  logic        sys_ack_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StStrobe, StWait, StResp, StVStrobe, StVWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            rsp_mismatch_q, rsp_mismatch_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      ready_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      ready_q        <= ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      rsp_timeout_q  <= rsp_timeout_d;
      rsp_mismatch_q <= rsp_mismatch_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    rsp_timeout_d  = rsp_timeout_q;
    rsp_mismatch_d = rsp_mismatch_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        // Counter holds the number of the current WAIT cycle (1-based).
        cnt_d   = CntOne;
        state_d = StWait;
      end
      StWait: begin
        if (sys_ack_i) begin
`ifdef PNR_SYSBUS_RDBACK_VERIFY_EN
          if (we_q && !sys_err_i) begin
            state_d = StVStrobe;
          end else begin
            state_d        = StResp;
            rsp_valid_d    = 1'b1;
            rsp_rdata_d    = we_q ? 32'h0 : sys_rdata_i;
            rsp_err_d      = sys_err_i;
            rsp_timeout_d  = 1'b0;
            rsp_mismatch_d = 1'b0;
          end
`else
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = we_q ? 32'h0 : sys_rdata_i;
          rsp_err_d      = sys_err_i;
          rsp_timeout_d  = 1'b0;
          rsp_mismatch_d = 1'b0;
`endif
        end else if (cnt_q == CntMax) begin
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = 32'h0;
          rsp_err_d      = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_mismatch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`ifdef PNR_SYSBUS_RDBACK_VERIFY_EN
      StVStrobe: begin
        cnt_d   = CntOne;
        state_d = StVWait;
      end
      StVWait: begin
        if (sys_ack_i) begin
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = sys_rdata_i;
          rsp_err_d      = sys_err_i;
          rsp_timeout_d  = 1'b0;
          rsp_mismatch_d = |((sys_rdata_i ^ wdata_q) & VERIFY_MASK);
        end else if (cnt_q == CntMax) begin
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = 32'h0;
          rsp_err_d      = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_mismatch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`endif
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so cmd_ready_o stays low while reset is asserted.
    ready_d = (state_d == StIdle);
  end

  assign cmd_ready_o   = ready_q;
  assign busy_o        = (state_q != StIdle);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign sys_addr_o    = addr_q;
  assign sys_wdata_o   = wdata_q;
  // Strobes decode straight from state so an async reset drops them at once.
  assign sys_wen_o     = (state_q == StStrobe) && we_q;
  assign sys_ren_o     = ((state_q == StStrobe) && !we_q) || (state_q == StVStrobe);

`ifdef PNR_SYSBUS_RDBACK_VERIFY_EN
  assign rsp_mismatch_o = rsp_mismatch_q;
`else
  logic unused_verify;
  assign unused_verify  = rsp_mismatch_q ^ (^VERIFY_MASK);
  assign rsp_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_pnr_sysbus_master.sv
// Directed bench for pnr_sysbus_master with a scoreboard of expected responses
// and a small delay-programmable bus slave model.
module tb_pnr_sysbus_master;

  localparam int unsigned To = 8;
`ifdef PNR_SYSBUS_RDBACK_VERIFY_EN
  localparam bit Vfy = 1'b1;
`else
  localparam bit Vfy = 1'b0;
`endif
  localparam int WrLat = Vfy ? 5 : 3;
  localparam int WrRen = Vfy ? 1 : 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
    logic        mismatch;
  } rsp_t;

  logic        clk_i, rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o, rsp_mismatch_o, busy_o;
  logic [31:0] sys_addr_o, sys_wdata_o, sys_rdata_i;
  logic        sys_wen_o, sys_ren_o, sys_err_i, sys_ack_i;

  pnr_sysbus_master #(.TIMEOUT_CYC(To), .VERIFY_MASK(32'h0000_3FFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .rsp_mismatch_o(rsp_mismatch_o),
    .busy_o(busy_o), .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i),
    .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rsp_t        exp_q[$];
  int          total, bad;
  int          cyc, acc_cyc, rise_cyc, strobe_cyc, pop_cyc, n_rsp, wen_cnt, ren_cnt;
  int          slv_delay, slv_cnt;
  logic [31:0] slv_rdata;
  logic        slv_err, stray_ack, valid_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [31:0] rd, input logic e, input logic t,
                              input logic m);
    rsp_t r;
    r.rdata = rd; r.err = e; r.timeout = t; r.mismatch = m;
    return r;
  endfunction

  // Expected response of an error-free write whose readback (if verified) returns rb.
  function automatic rsp_t exp_write(input logic [31:0] wd, input logic [31:0] rb);
    rsp_t r;
    r = '0;
    if (Vfy) begin
      r.rdata    = rb;
      r.mismatch = |((rb ^ wd) & 32'h0000_3FFF);
    end
    return r;
  endfunction

  // One clock: score handshakes due at the coming edge, then model the slave.
  task automatic tick();
    rsp_t e;
    logic acc;
    acc = cmd_valid_i && cmd_ready_o;
    if (acc) acc_cyc = cyc;
    if (rsp_valid_o && rsp_ready_i) begin
      n_rsp++;
      pop_cyc = cyc;
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, e.rdata);
        check("rsp_err", 32'(rsp_err_o), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout_o), 32'(e.timeout));
        check("rsp_mismatch", 32'(rsp_mismatch_o), 32'(e.mismatch));
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (acc) cmd_valid_i = 1'b0;
    sys_ack_i   = 1'b0;
    sys_err_i   = 1'b0;
    sys_rdata_i = 32'hDEAD_BEEF;
    if (slv_cnt > 0) begin
      slv_cnt--;
      if (slv_cnt == 0) begin
        sys_ack_i   = 1'b1;
        sys_rdata_i = slv_rdata;
        sys_err_i   = slv_err;
      end
    end
    if ((sys_wen_o || sys_ren_o) && slv_delay > 0) slv_cnt = slv_delay;
    if (stray_ack) sys_ack_i = 1'b1;
    if (sys_wen_o) begin
      wen_cnt++;
      strobe_cyc = cyc;
    end
    if (sys_ren_o) begin
      ren_cnt++;
      if (!Vfy || !cmd_we_i) strobe_cyc = cyc;
    end
    if (rsp_valid_o && !valid_prev) rise_cyc = cyc;
    valid_prev = rsp_valid_o;
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_valid_i = 1'b1;
    wen_cnt     = 0;
    ren_cnt     = 0;
  endtask

  task automatic slave(input int dly, input logic [31:0] rd, input logic e);
    slv_delay = dly;
    slv_rdata = rd;
    slv_err   = e;
  endtask

  task automatic run_until_rsp(input int target, input string tag);
    int n;
    n = 0;
    while (n_rsp < target && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(n_rsp), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_rdata;
    logic [2:0]  s_flags;
    int          p1, n0, n;
    total = 0; bad = 0; cyc = 0; n_rsp = 0; slv_cnt = 0; stray_ack = 1'b0; valid_prev = 1'b0;
    acc_cyc = 0; rise_cyc = 0; strobe_cyc = 0; pop_cyc = 0; wen_cnt = 0; ren_cnt = 0;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b1; sys_rdata_i = '0; sys_err_i = 1'b0; sys_ack_i = 1'b0;
    slave(1, 32'h0, 1'b0);
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_strobes", 32'({sys_wen_o, sys_ren_o}), 32'd0);
    check("rst_addr", sys_addr_o, 32'd0);
    rst_i = 1'b0;
    tick();
    check("ready_after_rst", 32'(cmd_ready_o), 32'd1);

    // Write 0x04 / 0x1234, ack one cycle after the strobe.
    slave(1, 32'h0000_1234, 1'b0);
    exp_q.push_back(exp_write(32'h0000_1234, 32'h0000_1234));
    send(1'b1, 32'h04, 32'h0000_1234);
    run_until_rsp(1, "wr_done");
    check("wr_wen_cycles", 32'(wen_cnt), 32'd1);
    check("wr_ren_cycles", 32'(ren_cnt), 32'(WrRen));
    check("wr_latency", 32'(rise_cyc - acc_cyc), 32'(WrLat));
    check("wr_addr", sys_addr_o, 32'h04);
    check("wr_wdata", sys_wdata_o, 32'h0000_1234);

    // Read 0x1C returning 0x0ABC.
    slave(1, 32'h0000_0ABC, 1'b0);
    exp_q.push_back(mk(32'h0000_0ABC, 1'b0, 1'b0, 1'b0));
    send(1'b0, 32'h1C, 32'h0);
    run_until_rsp(2, "rd_done");
    check("rd_wen_cycles", 32'(wen_cnt), 32'd0);
    check("rd_ren_cycles", 32'(ren_cnt), 32'd1);
    check("rd_latency", 32'(rise_cyc - acc_cyc), 32'd3);
    check("rd_addr", sys_addr_o, 32'h1C);

    // Slave never acks: timeout after To WAIT cycles.
    slave(0, 32'h0, 1'b0);
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0));
    send(1'b0, 32'h20, 32'h0);
    run_until_rsp(3, "to_done");
    check("to_strobe_to_valid", 32'(rise_cyc - strobe_cyc), 32'(To + 1));

    // Ack on the last counted WAIT cycle still succeeds.
    slave(To, 32'h0000_0055, 1'b0);
    exp_q.push_back(mk(32'h0000_0055, 1'b0, 1'b0, 1'b0));
    send(1'b0, 32'h24, 32'h0);
    run_until_rsp(4, "edge_ack_done");
    check("edge_ack_latency", 32'(rise_cyc - acc_cyc), 32'(To + 2));

    // Ack one cycle too late: timeout, and the late ack lands in RESP unused.
    slave(To + 1, 32'h0000_0066, 1'b0);
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0));
    send(1'b0, 32'h28, 32'h0);
    run_until_rsp(5, "late_ack_done");

    // Read with bus error.
    slave(2, 32'h0000_0099, 1'b1);
    exp_q.push_back(mk(32'h0000_0099, 1'b1, 1'b0, 1'b0));
    send(1'b0, 32'h2C, 32'h0);
    run_until_rsp(6, "rd_err_done");
    check("rd_err_latency", 32'(rise_cyc - acc_cyc), 32'd4);

    // Write with bus error: no verify read.
    slave(1, 32'h0000_0011, 1'b1);
    exp_q.push_back(mk(32'h0, 1'b1, 1'b0, 1'b0));
    send(1'b1, 32'h0C, 32'h0000_0042);
    run_until_rsp(7, "wr_err_done");
    check("wr_err_ren_cycles", 32'(ren_cnt), 32'd0);
    check("wr_err_latency", 32'(rise_cyc - acc_cyc), 32'd3);

    // Back-pressure: response held, second command blocked.
    rsp_ready_i = 1'b0;
    slave(1, 32'h0000_0077, 1'b0);
    exp_q.push_back(exp_write(32'h0000_ABCD, 32'h0000_0077));
    send(1'b1, 32'h08, 32'h0000_ABCD);
    n = 0;
    while (!rsp_valid_o && n < 40) begin
      tick();
      n++;
    end
    check("bp_valid", 32'(rsp_valid_o), 32'd1);
    s_rdata = rsp_rdata_o;
    s_flags = {rsp_err_o, rsp_timeout_o, rsp_mismatch_o};
    exp_q.push_back(mk(32'h0000_0077, 1'b0, 1'b0, 1'b0));
    send(1'b0, 32'h08, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_hold_rdata", rsp_rdata_o, s_rdata);
      check("bp_hold_flags", 32'({rsp_err_o, rsp_timeout_o, rsp_mismatch_o}), 32'(s_flags));
      check("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    tick();
    p1 = pop_cyc;
    check("bp_first_rsp", 32'(n_rsp), 32'd8);
    run_until_rsp(9, "bp_second_done");
    check("bp_accept_gap", 32'(acc_cyc - p1), 32'd1);

    // Reset asserted in the strobe cycle drops the strobe at once.
    slave(0, 32'h0, 1'b0);
    send(1'b0, 32'h30, 32'h0);
    tick();
    check("rst_strobe_seen", 32'(sys_ren_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_strobe_drop", 32'(sys_ren_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    slv_cnt = 0;
    tick();

    // Reset in WAIT, then a late ack must not produce a response.
    send(1'b0, 32'h34, 32'h0);
    tick(); tick(); tick();
    check("wait_busy", 32'(busy_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("wait_rst_busy", 32'(busy_o), 32'd0);
    check("wait_rst_ready", 32'(cmd_ready_o), 32'd0);
    check("wait_rst_strobes", 32'({sys_wen_o, sys_ren_o}), 32'd0);
    check("wait_rst_addr", sys_addr_o, 32'd0);
    check("wait_rst_rsp", 32'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_mismatch_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    slv_cnt = 0;
    n0 = n_rsp;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    repeat (5) tick();
    check("stray_no_rsp", 32'(n_rsp), 32'(n0));
    check("stray_no_valid", 32'(rsp_valid_o), 32'd0);

    slave(1, 32'h1234_5678, 1'b0);
    exp_q.push_back(mk(32'h1234_5678, 1'b0, 1'b0, 1'b0));
    send(1'b0, 32'h10, 32'h0);
    run_until_rsp(n0 + 1, "post_rst_done");
    check("post_rst_latency", 32'(rise_cyc - acc_cyc), 32'd3);

`ifdef PNR_SYSBUS_RDBACK_VERIFY_EN
    slave(1, 32'h0000_1FFF, 1'b0);
    exp_q.push_back(mk(32'h0000_1FFF, 1'b0, 1'b0, 1'b1));
    send(1'b1, 32'h04, 32'h0000_3FFF);
    run_until_rsp(n0 + 2, "vfy_bad_done");
    slave(1, 32'hFFFF_FFFF, 1'b0);
    exp_q.push_back(mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    send(1'b1, 32'h04, 32'h0000_3FFF);
    run_until_rsp(n0 + 3, "vfy_clean_done");
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
